// File: rtl/seq_count_timer.sv
// seq_count_timer: minutes:seconds up-counting stopwatch.
// Counts one second on every rising edge where tick and run are both high,
// clears synchronously on restart, and saturates at 59:59 instead of wrapping.
// mins/secs come straight from flops; no input reaches an output combinationally.
module seq_count_timer (
    input  logic       clk,
    input  logic       reset,     // asynchronous, active-low
    input  logic       restart,   // synchronous clear to 00:00
    input  logic       tick,      // one-second strobe
    input  logic       run,       // count enable
    output logic [5:0] mins,
    output logic [5:0] secs
);

    localparam logic [5:0] LAST_VAL = 6'd59;

    logic [5:0] mins_q, mins_d;
    logic [5:0] secs_q, secs_d;

    logic count_en;
    logic secs_last;
    logic at_max;

    assign count_en  = tick & run;
    assign secs_last = (secs_q == LAST_VAL);
    // 59:59 is the terminal state; a count step there must hold, not wrap.
    assign at_max    = secs_last && (mins_q == LAST_VAL);

    // Next-state: restart beats counting; counting carries seconds into minutes.
    always_comb begin
        mins_d = mins_q;
        secs_d = secs_q;
        if (restart) begin
            mins_d = '0;
            secs_d = '0;
        end else if (count_en && !at_max) begin
            if (secs_last) begin
                secs_d = '0;
                mins_d = mins_q + 6'd1;
            end else begin
                secs_d = secs_q + 6'd1;
            end
        end
    end

    // State register; reset clears without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mins_q <= '0;
            secs_q <= '0;
        end else begin
            mins_q <= mins_d;
            secs_q <= secs_d;
        end
    end

    assign mins = mins_q;
    assign secs = secs_q;

endmodule

// File: tb/tb_seq_count_timer.sv
// Directed testbench for seq_count_timer with hand-computed expected values.
module tb_seq_count_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       restart;
    logic       tick;
    logic       run;
    logic [5:0] mins;
    logic [5:0] secs;

    int n_tests = 0;
    int n_fail  = 0;

    seq_count_timer dut (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick),
        .run     (run),
        .mins    (mins),
        .secs    (secs)
    );

    always #5 clk = ~clk;

    // Compare {mins,secs} against expected minutes/seconds.
    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d:%0d expected %0d:%0d", tag,
                     got[11:6], got[5:0], exp[11:6], exp[5:0]);
        end
    endtask

    function automatic logic [11:0] mmss(input int m, input int s);
        logic [5:0] mm;
        logic [5:0] ss;
        mm = 6'(m);
        ss = 6'(s);
        return {mm, ss};
    endfunction

    // Apply inputs just after an edge, let one edge pass, sample 1 time unit after it.
    task automatic cyc(input logic t, input logic r, input logic rs);
        tick    = t;
        run     = r;
        restart = rs;
        @(posedge clk);
        #1;
    endtask

    int exp_m, exp_s, tot;
    logic t_r, r_r, rs_r, rst_r;

    initial begin
        reset = 1'b0; restart = 1'b0; tick = 1'b0; run = 1'b0;
        #1;
        check("reset_async", {mins, secs}, mmss(0, 0));
        @(posedge clk); #1;
        cyc(1, 1, 0);
        check("reset_held", {mins, secs}, mmss(0, 0));
        reset = 1'b1;

        // Basic count
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 1, 0);
            check("basic", {mins, secs}, mmss(0, i));
        end

        // Tick gating with run high
        cyc(1, 1, 1);
        check("restart_clear", {mins, secs}, mmss(0, 0));
        for (int i = 0; i < 9; i++) begin
            cyc((i % 3) == 0, 1, 0);
            check("tick_gate", {mins, secs}, mmss(0, i / 3 + 1));
        end

        // Run gating with tick high
        cyc(1, 1, 1);
        for (int i = 0; i < 9; i++) begin
            cyc(1, (i % 3) == 0, 0);
            check("run_gate", {mins, secs}, mmss(0, i / 3 + 1));
        end

        // Seconds wraparound into minutes
        cyc(0, 0, 1);
        for (int c = 1; c <= 150; c++) begin
            cyc(1, 1, 0);
            check("wrap", {mins, secs}, mmss(c / 60, c % 60));
        end
        check("wrap_final", {mins, secs}, mmss(2, 30));

        // Saturation at 59:59
        cyc(0, 0, 1);
        for (int c = 1; c <= 3610; c++) begin
            tot = (c > 3599) ? 3599 : c;
            cyc(1, 1, 0);
            check("saturate", {mins, secs}, mmss(tot / 60, tot % 60));
        end
        cyc(0, 1, 0);
        check("sat_hold_idle", {mins, secs}, mmss(59, 59));
        cyc(1, 1, 1);
        check("sat_restart", {mins, secs}, mmss(0, 0));

        // Restart held for 3 cycles with counting active
        for (int i = 1; i <= 7; i++) cyc(1, 1, 0);
        check("pre_restart", {mins, secs}, mmss(0, 7));
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 1);
            check("restart_hold", {mins, secs}, mmss(0, 0));
        end
        for (int i = 1; i <= 3; i++) begin
            cyc(1, 1, 0);
            check("after_restart", {mins, secs}, mmss(0, i));
        end

        // Reset held for 3 cycles with counting active
        cyc(1, 1, 1);
        for (int i = 1; i <= 7; i++) cyc(1, 1, 0);
        check("pre_reset", {mins, secs}, mmss(0, 7));
        reset = 1'b0;
        #1;
        check("reset_immediate", {mins, secs}, mmss(0, 0));
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0);
            check("reset_hold", {mins, secs}, mmss(0, 0));
        end
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc(1, 1, 0);
            check("after_reset", {mins, secs}, mmss(0, i));
        end

        // Random phases: tick/run, then +restart, then +reset
        exp_m = 0; exp_s = 3;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 50; i++) begin
                t_r   = 1'($urandom_range(0, 1));
                r_r   = 1'($urandom_range(0, 1));
                rs_r  = (p >= 1) && ($urandom_range(0, 7) == 0);
                rst_r = (p == 2) && ($urandom_range(0, 7) == 0);
                reset = ~rst_r;
                if (rst_r || rs_r) begin
                    exp_m = 0; exp_s = 0;
                end else if (t_r && r_r && !(exp_m == 59 && exp_s == 59)) begin
                    if (exp_s == 59) begin
                        exp_s = 0; exp_m = exp_m + 1;
                    end else begin
                        exp_s = exp_s + 1;
                    end
                end
                cyc(t_r, r_r, rs_r);
                check("random", {mins, secs}, mmss(exp_m, exp_s));
                check("range", {11'd0, (mins > 6'd59) || (secs > 6'd59)}, 12'd0);
            end
        end
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
